skin_bbox: RTL
==============

// Module: skin_bbox
// PURPOSE
//  Consumes the H/S/V pixel stream and syncs from the colour-space converter. Thresholds each pixel into a binary
//  skin mask, forwarded as video (0x00/0xFF on all three channels) for display.
//  Tracks per-frame skin statistics: bounding box and pixel count. Reports them once per frame at vsync rise
//  to the downstream tracking/overlay logic.
// PARAMETERS
//  H_MIN   8'd0    hue lower bound (inclusive); if H_MIN > H_MAX the hue window wraps through 0
//  H_MAX   8'd35   hue upper bound (inclusive)
//  S_MIN   8'd40   saturation lower bound (inclusive)
//  S_MAX   8'd200  saturation upper bound (inclusive)
//  V_MIN   8'd60   value lower bound (inclusive)
//  XW      11      x coordinate width
//  YW      11      y coordinate width
//  CW      21      skin pixel count width
// PORTS
//  clk         in   1   pixel clock
//  rst         in   1   synchronous, active-high reset
//  ce          in   1   clock enable; when low every register holds
//  de_in       in   1   data enable, active high
//  hsync_in    in   1   hsync, passed through
//  vsync_in    in   1   vsync, active high; rising edge = frame boundary
//  h_in        in   8   hue 0..255
//  s_in        in   8   saturation 0..255
//  v_in        in   8   value 0..255
//  mask_r      out  8   0xFF if skin, else 0x00
//  mask_g      out  8   same as mask_r
//  mask_b      out  8   same as mask_r
//  de_out      out  1   de_in delayed 1 cycle
//  hsync_out   out  1   hsync_in delayed 1 cycle
//  vsync_out   out  1   vsync_in delayed 1 cycle
//  x_min       out  XW  bbox left, last reported frame
//  x_max       out  XW  bbox right
//  y_min       out  YW  bbox top
//  y_max       out  YW  bbox bottom
//  skin_count  out  CW  skin pixels in last reported frame, saturating
//  bbox_empty  out  1   last reported frame contained no skin pixels
//  bbox_valid  out  1   one-cycle pulse when the report outputs update
// BEHAVIOUR
//  Reset values:
//  - all outputs 0, except bbox_empty=1
//  - state WAIT_FRAME; x=y=0; accumulators cleared
//  Skin test:
//  - skin = de_in & hue_ok & (S_MIN<=s<=S_MAX) & (v>=V_MIN)
//  - hue_ok = (H_MIN<=h<=H_MAX), or (h>=H_MIN | h<=H_MAX) when H_MIN>H_MAX
//  Pixel path:
//  - mask and sync outputs registered; latency exactly 1 ce-cycle
//  - mask is 0 whenever de is low
//  Position counters (advance only when ce=1):
//  - x increments on each de_in=1 cycle and clears on the de falling edge
//  - y increments on the de falling edge and clears on the vsync rising edge
//  - x and y saturate at all-ones; they never wrap
//  - the current pixel uses the x/y values from before the increment (first pixel = (0,0))
//  FSM WAIT_FRAME -> ACTIVE -> REPORT -> ACTIVE:
//  - WAIT_FRAME: ignore pixels; on vsync rise -> ACTIVE, clear accumulators, no report
//  - ACTIVE: on each skin pixel:
//    - count += 1 (saturating)
//    - min/max updated; the first skin pixel of the frame loads all four bounds
//    - on vsync rise -> REPORT
//  - REPORT (one cycle):
//    - latch count, bounds and empty flag (empty = no skin pixel seen)
//    - bbox_valid=1; clear accumulators; -> ACTIVE
//    - vsync is still high in this cycle, so no pixel can be lost
//  Empty frame: bounds reported as 0 and bbox_empty=1.
//  Simultaneous events:
//  - vsync rise and a skin pixel in the same cycle: the pixel is ignored (de is inactive during vsync in valid timing)
//  Mid-operation reset:
//  - the partial frame is discarded; report outputs return to reset values
//  - the first bbox_valid comes at the second vsync rise after reset
//  ce low: bbox_valid is held low; the FSM holds its state.
// STRUCTURE
//  Shared package skin_pkg:
//  - default threshold constants
//  - XW/YW/CW defaults
//  - FSM state enum {WAIT_FRAME, ACTIVE, REPORT}
//  One sub-module, video_pos_counter:
//  - sync edge detection plus x/y counters
//  - reusable by other overlay stages
//  The top level holds the threshold compare, the accumulators and the FSM.
// TESTING
//  1. Reset, then drive 2 frames of 8x4 pixels with no skin (h=128):
//     - mask=0x00 throughout
//     - one bbox_valid at the 2nd vsync rise: bbox_empty=1, skin_count=0
//  2. Frame with skin (h=10, s=100, v=100) at pixels (2,1),(5,1),(3,3):
//     - at the next vsync rise: x_min=2, x_max=5, y_min=1, y_max=3, count=3, empty=0
//     - mask=0xFF exactly 1 cycle after each of those pixels
//  3. Hue wrap with H_MIN=240, H_MAX=15:
//     - h=250 and h=5 are skin; h=100 is not
//  4. Boundary values:
//     - s=S_MIN and s=S_MAX are skin; s=S_MAX+1 is not
//     - v=V_MIN-1 is not skin
//  5. Assert rst mid-frame:
//     - outputs return to reset values
//     - no bbox_valid at the 1st vsync rise after reset; valid at the 2nd
//  6. Toggle ce low for 3 cycles mid-line:
//     - outputs and counters freeze; resulting bounds equal those of the ce=1 reference run

Source files
------------

// File: rtl/skin_pkg.sv
// skin_pkg: shared definitions for the skin-mask / bounding-box pipeline.
//   - default colour thresholds (HSV, 8-bit per channel)
//   - default coordinate and pixel-count widths
//   - tracker FSM state type
//   - small unsigned range helpers. These keep compares against a zero-valued
//     parameter from collapsing into a constant.
package skin_pkg;

  localparam logic [7:0] H_MIN_DEF = 8'd0;
  localparam logic [7:0] H_MAX_DEF = 8'd35;
  localparam logic [7:0] S_MIN_DEF = 8'd40;
  localparam logic [7:0] S_MAX_DEF = 8'd200;
  localparam logic [7:0] V_MIN_DEF = 8'd60;

  localparam int XW_DEF = 11;
  localparam int YW_DEF = 11;
  localparam int CW_DEF = 21;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    REPORT     = 2'd2
  } state_t;

  function automatic logic ge8(input logic [7:0] val, input logic [7:0] lo);
    return val >= lo;
  endfunction

  function automatic logic le8(input logic [7:0] val, input logic [7:0] hi);
    return val <= hi;
  endfunction

endpackage

// File: rtl/skin_bbox_pos.sv
// video_pos_counter: sync edge detection plus pixel x/y position counters.
// It can be reused by any overlay stage that needs raster coordinates.
// Ports:
//   clk, rst, ce   pixel clock, synchronous active-high reset, clock enable
//   i_de           data enable
//   i_vsync        vsync, active high
//   o_x, o_y       position of the pixel currently on the inputs. This is the
//                  value before the increment, so the first pixel is (0,0).
//   o_vsync_rise   combinational vsync rising-edge flag for the current cycle
module video_pos_counter
  import skin_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          i_de,
  input  logic          i_vsync,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_vsync_rise
);

  logic          r_de_d;
  logic          r_vs_d;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_de_fall;

  assign w_de_fall    = ~i_de & r_de_d;
  assign o_vsync_rise = i_vsync & ~r_vs_d;
  assign o_x          = r_x;
  assign o_y          = r_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_de_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (ce) begin
      r_de_d <= i_de;
      r_vs_d <= i_vsync;

      // Both counters saturate at all-ones. This keeps oversized rasters from
      // wrapping back into a small, plausible-looking bounding box.
      if (i_de) begin
        if (r_x != '1) r_x <= r_x + 1'b1;
      end else if (w_de_fall) begin
        r_x <= '0;
      end

      if (o_vsync_rise) begin
        r_y <= '0;
      end else if (w_de_fall && (r_y != '1)) begin
        r_y <= r_y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/skin_bbox.sv
// skin_bbox: thresholds an HSV pixel stream into a binary skin mask. The mask
// is forwarded as 0x00/0xFF video. The module also reports the skin bounding
// box and the skin pixel count once per frame.
// Ports:
//   clk, rst, ce                 pixel clock, sync active-high reset, clock enable
//   de_in, hsync_in, vsync_in    input syncs (vsync rise = frame boundary)
//   h_in, s_in, v_in             pixel colour
//   mask_r/g/b                   0xFF for a skin pixel, otherwise 0x00 (1-cycle latency)
//   de_out, hsync_out, vsync_out input syncs delayed by one cycle
//   x_min, x_max, y_min, y_max   bounding box of the last reported frame
//   skin_count                   skin pixels in the last reported frame (saturating)
//   bbox_empty                   set when the last reported frame had no skin
//   bbox_valid                   one-cycle pulse when the report outputs update
//
// state      | meaning
// WAIT_FRAME | after reset; pixels ignored until the first frame boundary
// ACTIVE     | accumulating skin statistics for the current frame
// REPORT     | one cycle: publish the totals and restart the accumulators
module skin_bbox
  import skin_pkg::*;
#(
  parameter logic [7:0] H_MIN = H_MIN_DEF,
  parameter logic [7:0] H_MAX = H_MAX_DEF,
  parameter logic [7:0] S_MIN = S_MIN_DEF,
  parameter logic [7:0] S_MAX = S_MAX_DEF,
  parameter logic [7:0] V_MIN = V_MIN_DEF,
  parameter int         XW    = XW_DEF,
  parameter int         YW    = YW_DEF,
  parameter int         CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          de_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [7:0]    h_in,
  input  logic [7:0]    s_in,
  input  logic [7:0]    v_in,
  output logic [7:0]    mask_r,
  output logic [7:0]    mask_g,
  output logic [7:0]    mask_b,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [CW-1:0] skin_count,
  output logic          bbox_empty,
  output logic          bbox_valid
);

  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_vs_rise;
  logic          w_hue_ok;
  logic          w_skin;

  state_t        r_state;
  logic [7:0]    r_mask;
  logic          r_de_out, r_hs_out, r_vs_out;
  logic          r_acc_seen;
  logic [CW-1:0] r_acc_cnt;
  logic [XW-1:0] r_acc_x_min, r_acc_x_max;
  logic [YW-1:0] r_acc_y_min, r_acc_y_max;
  logic [XW-1:0] r_x_min, r_x_max;
  logic [YW-1:0] r_y_min, r_y_max;
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_valid;

  video_pos_counter #(.XW(XW), .YW(YW)) u_pos (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .i_de         (de_in),
    .i_vsync      (vsync_in),
    .o_x          (w_x),
    .o_y          (w_y),
    .o_vsync_rise (w_vs_rise)
  );

  // If H_MIN > H_MAX, the hue window wraps through 0 (red sits on both ends of
  // the hue circle).
  assign w_hue_ok = (H_MIN <= H_MAX) ? (ge8(h_in, H_MIN) & le8(h_in, H_MAX))
                                     : (ge8(h_in, H_MIN) | le8(h_in, H_MAX));
  assign w_skin   = de_in & w_hue_ok & ge8(s_in, S_MIN) & le8(s_in, S_MAX)
                  & ge8(v_in, V_MIN);

  assign mask_r     = r_mask;
  assign mask_g     = r_mask;
  assign mask_b     = r_mask;
  assign de_out     = r_de_out;
  assign hsync_out  = r_hs_out;
  assign vsync_out  = r_vs_out;
  assign x_min      = r_x_min;
  assign x_max      = r_x_max;
  assign y_min      = r_y_min;
  assign y_max      = r_y_max;
  assign skin_count = r_count;
  assign bbox_empty = r_empty;
  assign bbox_valid = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_FRAME;
      r_mask      <= 8'h00;
      r_de_out    <= 1'b0;
      r_hs_out    <= 1'b0;
      r_vs_out    <= 1'b0;
      r_acc_seen  <= 1'b0;
      r_acc_cnt   <= '0;
      r_acc_x_min <= '0;
      r_acc_x_max <= '0;
      r_acc_y_min <= '0;
      r_acc_y_max <= '0;
      r_x_min     <= '0;
      r_x_max     <= '0;
      r_y_min     <= '0;
      r_y_max     <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_valid     <= 1'b0;
    end else if (ce) begin
      r_mask   <= w_skin ? 8'hFF : 8'h00;
      r_de_out <= de_in;
      r_hs_out <= hsync_in;
      r_vs_out <= vsync_in;
      r_valid  <= 1'b0;

      case (r_state)
        WAIT_FRAME: begin
          if (w_vs_rise) begin
            r_state     <= ACTIVE;
            r_acc_seen  <= 1'b0;
            r_acc_cnt   <= '0;
            r_acc_x_min <= '0;
            r_acc_x_max <= '0;
            r_acc_y_min <= '0;
            r_acc_y_max <= '0;
          end
        end

        ACTIVE: begin
          // A skin pixel that arrives on the vsync edge is dropped. With valid
          // video timing, de is low here anyway.
          if (w_vs_rise) begin
            r_state <= REPORT;
          end else if (w_skin) begin
            if (r_acc_cnt != '1) r_acc_cnt <= r_acc_cnt + 1'b1;
            r_acc_seen <= 1'b1;
            if (!r_acc_seen) begin
              r_acc_x_min <= w_x;
              r_acc_x_max <= w_x;
              r_acc_y_min <= w_y;
              r_acc_y_max <= w_y;
            end else begin
              if (w_x < r_acc_x_min) r_acc_x_min <= w_x;
              if (w_x > r_acc_x_max) r_acc_x_max <= w_x;
              if (w_y < r_acc_y_min) r_acc_y_min <= w_y;
              if (w_y > r_acc_y_max) r_acc_y_max <= w_y;
            end
          end
        end

        REPORT: begin
          // vsync is still high in this cycle, so no pixel can arrive here.
          // Bounds of an empty frame are already 0 from the accumulator clear.
          r_x_min     <= r_acc_x_min;
          r_x_max     <= r_acc_x_max;
          r_y_min     <= r_acc_y_min;
          r_y_max     <= r_acc_y_max;
          r_count     <= r_acc_cnt;
          r_empty     <= ~r_acc_seen;
          r_valid     <= 1'b1;
          r_acc_seen  <= 1'b0;
          r_acc_cnt   <= '0;
          r_acc_x_min <= '0;
          r_acc_x_max <= '0;
          r_acc_y_min <= '0;
          r_acc_y_max <= '0;
          r_state     <= ACTIVE;
        end

        default: r_state <= WAIT_FRAME;
      endcase
    end else begin
      r_valid <= 1'b0;
    end
  end

endmodule
